ezm_prog_sequencer: RTL and testbench
=====================================

# ezm_prog_sequencer

- Program sequencer and run controller for the 6-bit-instruction accumulator CPU core.
- Holds a 16-word × 6-bit program store, loaded through a valid/ready port.
- Holds the CPU in reset, then releases it and feeds it one instruction word per fetch/execute pair, following the CPU's own PC so branches work unmodified.
- Stops issue on end-of-program, breakpoint or instruction limit, then captures final PC and accumulator for the host.

## Interface

Parameters
- MAX_INSTR, 200: issued-instruction limit; reaching it halts with cause 11.
- RST_CYCLES, 2: cycles `cpu_rst` is held high in RESET (≥1).

Ports
- clk  in  1  single clock, shared with the CPU core.
- rst  in  1  asynchronous, active-high reset for this block.
- cmd_valid  in  1  command strobe.
- cmd_op  in  2  01 start, 11 abort; 00/10 ignored but still accepted.
- cmd_ready  out  1  1 in IDLE and DONE; abort is accepted in any state.
- ld_valid  in  1  program-write strobe.
- ld_ready  out  1  1 in IDLE and DONE only.
- ld_addr  in  4  program-store word address.
- ld_data  in  6  instruction word.
- prog_len  in  5  program length 0..16; sampled on start.
- bp_en  in  1  breakpoint enable; sampled on start.
- bp_addr  in  4  breakpoint PC; sampled on start.
- cpu_rst  out  1  drives the CPU reset input.
- cpu_in  out  6  drives the CPU instruction input.
- cpu_out  in  8  CPU output: PC in fetch phase, accumulator in execute phase.
- busy  out  1  1 in RESET, RUN, DRAIN.
- done  out  1  1 in DONE.
- halt_cause  out  2  00 none, 01 end, 10 breakpoint, 11 limit.
- final_pc  out  8  PC sampled at halt.
- final_acc  out  8  accumulator sampled in DRAIN.
- instr_count  out  8  instructions issued in the last or current run.

## Operation

- States: IDLE, RESET, RUN, DRAIN, DONE.
- `phase` register: 0 = fetch, 1 = execute. Cleared whenever `cpu_rst` = 1; toggles every cycle in RUN and DRAIN.
- `rst` asserted clears all state at once:
  - state = IDLE, `cpu_rst` = 1, `cpu_in` = 0, `phase` = 0;
  - all status outputs and counters = 0;
  - program store cleared to 000000 (the CPU's NOP).
- Load: a write occurs on `ld_valid & ld_ready`: mem[ld_addr] ← ld_data. The last write wins. Writes while not ready are dropped.
- Start (`cmd_op` = 01 accepted in IDLE or DONE):
  - latch `prog_len`, `bp_en`, `bp_addr`;
  - clear `instr_count`, `halt_cause`, `final_pc`, `final_acc`;
  - go to RESET.
- RESET: `cpu_rst` = 1 for RST_CYCLES cycles, then RUN with `phase` = 0.
- RUN, phase 0 (`cpu_out` = PC), halt checks in priority order:
  - PC ≥ prog_len → 01 (this also covers PC > 15);
  - bp_en & PC = bp_addr → 10;
  - instr_count = MAX_INSTR → 11.
- RUN, phase 0, on halt:
  - `cpu_in` = 000000 combinationally this cycle;
  - final_pc ← PC, halt_cause ← cause;
  - go to DRAIN.
- RUN, phase 0, otherwise:
  - `cpu_in` = mem[PC[3:0]] combinationally;
  - IR ← that word;
  - instr_count += 1, saturating at 255.
- RUN, phase 1: `cpu_in` = IR, so the operand matches the decode.
- The CPU's branch (PC − accumulator) is followed implicitly, because the next phase-0 read uses `cpu_out`.
- DRAIN: a single phase-1 cycle.
  - `cpu_in` = 000000;
  - final_acc ← `cpu_out`; the NOP leaves the accumulator unchanged;
  - go to DONE.
- DONE:
  - `cpu_rst` stays 0 and `cpu_in` = 000000; the CPU free-runs NOPs, which is harmless;
  - status outputs are held until the next start, abort or `rst`.
- Abort (`cmd_op` = 11 in any state):
  - next state IDLE, `cpu_rst` = 1;
  - status outputs keep their values;
  - program store untouched.
- Start accepted in the same cycle as a load: the write completes and is visible to the run.
- prog_len = 0: the first fetch halts with cause 01 and instr_count = 0.

## Timing

- `cpu_rst` is registered. It rises the cycle after abort or `rst` release handling, and falls on the first RUN cycle.
- Start accepted at edge T:
  - RESET spans T+1 .. T+RST_CYCLES;
  - first fetch cycle at T+RST_CYCLES+1.
- One instruction costs 2 cycles.
- Halt detected at fetch cycle F: DRAIN at F+1; `done` = 1 from F+2.
- Run latency = RST_CYCLES + 2·N + 2 cycles after start acceptance.
- The `cpu_in` fetch path is combinational from `cpu_out` (a CPU register) through the store read.
- `cmd_ready` and `ld_ready` are Moore outputs.

## Test plan

- Load 100011, 001000, 010000 at 0..2; prog_len = 3; start → done after 10 cycles; final_acc = 6, final_pc = 3, cause 01, instr_count = 3.
- Same program with bp_en = 1, bp_addr = 2 → cause 10, final_pc = 2, final_acc = 3, instr_count = 2.
- Program 100001, 001001, 100011, 011001; prog_len = 4. The branch repeats; PC never reaches 4 → cause 11, instr_count = 200.
- prog_len = 0 → done 4 cycles after start, cause 01, instr_count = 0, final_acc = 0.
- Abort in mid-RUN → next cycle IDLE, `cpu_rst` = 1, `ld_ready` = 1. A ld_valid issued during RUN is dropped and the store is unchanged.
- Assert `rst` mid-RUN → all outputs 0 immediately and `cpu_rst` = 1. A restart after reloading gives identical results.

Source files
------------

// File: rtl/ezm_prog_sequencer.sv
// ezm_prog_sequencer: program store, reset/run control and halt capture for the 6-bit accumulator CPU core
// Ports:
//   clk, rst                     clock shared with the CPU, async active-high reset
//   cmd_valid/cmd_op/cmd_ready   command port: 01 start, 11 abort (abort accepted in any state)
//   ld_valid/ld_ready/ld_addr/ld_data  program-store write port
//   prog_len, bp_en, bp_addr     run configuration, sampled on start
//   cpu_rst, cpu_in, cpu_out     CPU reset, instruction feed, PC/accumulator readback
//   busy, done, halt_cause, final_pc, final_acc, instr_count  run status
module ezm_prog_sequencer #(
   parameter int MAX_INSTR  = 200,
   parameter int RST_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_op,
   output logic       cmd_ready,
   input  logic       ld_valid,
   output logic       ld_ready,
   input  logic [3:0] ld_addr,
   input  logic [5:0] ld_data,
   input  logic [4:0] prog_len,
   input  logic       bp_en,
   input  logic [3:0] bp_addr,
   output logic       cpu_rst,
   output logic [5:0] cpu_in,
   input  logic [7:0] cpu_out,
   output logic       busy,
   output logic       done,
   output logic [1:0] halt_cause,
   output logic [7:0] final_pc,
   output logic [7:0] final_acc,
   output logic [7:0] instr_count
);
   typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE} state_t;
   state_t      state, nxt;
   logic [5:0]  mem [16];
   logic [5:0]  ir;
   logic        phase;
   logic [4:0]  plen;
   logic        bp_on;
   logic [3:0]  bp;
   logic [15:0] rcnt;
   logic        start, abort, fetch, halt;
   logic [1:0]  cause;

   assign cmd_ready = state == IDLE || state == DONE;
   assign ld_ready  = cmd_ready;
   assign busy      = state == RESET || state == RUN || state == DRAIN;
   assign done      = state == DONE;
   assign start     = cmd_valid && cmd_ready && cmd_op == 2'b01;
   assign abort     = cmd_valid && cmd_op == 2'b11;
   assign fetch     = state == RUN && !phase;
   // in the fetch phase cpu_out is the PC; checks are in priority order
   assign cause     = cpu_out >= {3'b0, plen} ? 2'b01 :
                      (bp_on && cpu_out == {4'b0, bp}) ? 2'b10 :
                      32'(instr_count) == MAX_INSTR ? 2'b11 : 2'b00;
   assign halt      = fetch && cause != 2'b00;
   // a halting fetch feeds a NOP so the DRAIN execute leaves the accumulator intact
   assign cpu_in    = fetch ? (halt ? 6'b0 : mem[cpu_out[3:0]]) : state == RUN ? ir : 6'b0;

   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: if (start) nxt = RESET;
         RESET:      if (32'(rcnt) == RST_CYCLES - 1) nxt = RUN;
         RUN:        if (halt) nxt = DRAIN;
         DRAIN:      nxt = DONE;
         default:    nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cpu_rst     <= 1'b1;
         phase       <= 1'b0;
         ir          <= '0;
         plen        <= '0;
         bp_on       <= 1'b0;
         bp          <= '0;
         rcnt        <= '0;
         instr_count <= '0;
         halt_cause  <= '0;
         final_pc    <= '0;
         final_acc   <= '0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else begin
         state   <= nxt;
         cpu_rst <= nxt == IDLE || nxt == RESET;
         // phase only toggles while staying within RUN/DRAIN, so entering RUN starts at fetch
         phase   <= ((state == RUN || state == DRAIN) && (nxt == RUN || nxt == DRAIN)) ? ~phase : 1'b0;
         rcnt    <= state == RESET ? rcnt + 16'd1 : '0;
         if (ld_valid && ld_ready) mem[ld_addr] <= ld_data;
         if (start) begin
            plen        <= prog_len;
            bp_on       <= bp_en;
            bp          <= bp_addr;
            instr_count <= '0;
            halt_cause  <= '0;
            final_pc    <= '0;
            final_acc   <= '0;
         end
         if (fetch && !halt && !abort) begin
            ir          <= mem[cpu_out[3:0]];
            instr_count <= instr_count + 8'(instr_count != 8'hff);
         end
         if (halt && !abort) begin
            final_pc   <= cpu_out;
            halt_cause <= cause;
         end
         if (state == DRAIN && !abort) final_acc <= cpu_out;
      end
   end
endmodule

// File: tb/tb_ezm_prog_sequencer.sv
// tb_ezm_prog_sequencer: directed checks of ezm_prog_sequencer driving a small accumulator CPU model
module tb_ezm_prog_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic       cmd_ready;
   logic       ld_valid = 1'b0;
   logic       ld_ready;
   logic [3:0] ld_addr = '0;
   logic [5:0] ld_data = '0;
   logic [4:0] prog_len = '0;
   logic       bp_en = 1'b0;
   logic [3:0] bp_addr = '0;
   logic       cpu_rst;
   logic [5:0] cpu_in;
   logic [7:0] cpu_out;
   logic       busy, done;
   logic [1:0] halt_cause;
   logic [7:0] final_pc, final_acc, instr_count;
   int         errs = 0;
   int         checks = 0;
   int         lat;

   always #5 clk = ~clk;

   ezm_prog_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .prog_len(prog_len), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_rst(cpu_rst), .cpu_in(cpu_in),
      .cpu_out(cpu_out), .busy(busy), .done(done), .halt_cause(halt_cause), .final_pc(final_pc),
      .final_acc(final_acc), .instr_count(instr_count)
   );

   // CPU model: fetch latches opcode [5:3], execute uses operand [2:0] from the execute-phase word
   // ops: 1 add imm, 2 double, 3 pc = pc - acc, 4 load imm, others NOP
   logic [7:0] pc, acc;
   logic       cph;
   logic [2:0] cop;
   assign cpu_out = cph ? acc : pc;
   always @(posedge clk) begin
      if (cpu_rst) begin
         pc <= 0; acc <= 0; cph <= 0; cop <= 0;
      end else if (!cph) begin
         cop <= cpu_in[5:3];
         cph <= 1'b1;
      end else begin
         cph <= 1'b0;
         case (cop)
            3'd1: acc <= acc + {5'b0, cpu_in[2:0]};
            3'd2: acc <= acc << 1;
            3'd4: acc <= {5'b0, cpu_in[2:0]};
            default: ;
         endcase
         pc <= cop == 3'd3 ? pc - acc : pc + 8'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic ld(input logic [3:0] a, input logic [5:0] d);
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic start(input string tag, input logic [4:0] len, input logic be, input logic [3:0] ba);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b01; prog_len = len; bp_en = be; bp_addr = ba;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'b00;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_cpurst"}, cpu_rst, 1);
      chk({tag, "_ldrdy"}, ld_ready, 0);
   endtask

   task automatic run_chk(input string tag, input logic [4:0] len, input logic be, input logic [3:0] ba,
                          input int xlat, input int xcause, input int xpc, input int xacc, input int xcnt);
      start(tag, len, be, ba);
      lat = 0;
      while (lat < 1000 && !done) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_lat"}, lat, xlat);
      chk({tag, "_cause"}, halt_cause, xcause);
      chk({tag, "_pc"}, final_pc, xpc);
      chk({tag, "_acc"}, final_acc, xacc);
      chk({tag, "_cnt"}, instr_count, xcnt);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cpurst", cpu_rst, 1);
      chk("rst_cpuin", cpu_in, 0);
      chk("rst_cnt", instr_count, 0);
      chk("rst_ready", {cmd_ready, ld_ready}, 2'b11);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_cpurst", cpu_rst, 1);
      ld(0, 6'b100011); ld(1, 6'b001000); ld(2, 6'b010000);
      run_chk("end", 3, 0, 0, 10, 1, 3, 6, 3);
      chk("done_cpurst", cpu_rst, 0);
      chk("done_cpuin", cpu_in, 0);
      chk("done_busy", busy, 0);
      run_chk("bp", 3, 1, 2, 8, 2, 2, 3, 2);
      run_chk("len0", 0, 0, 0, 4, 1, 0, 0, 0);
      ld(0, 6'b100001); ld(1, 6'b001001); ld(2, 6'b100011); ld(3, 6'b011001);
      run_chk("limit", 4, 0, 0, 404, 3, 0, 3, 200);
      start("abort", 4, 0, 0);
      repeat (9) @(negedge clk);
      ld_valid = 1'b1; ld_addr = 0; ld_data = 6'b111111;
      @(negedge clk);
      ld_valid = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'b11;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'b00;
      chk("abort_busy", busy, 0);
      chk("abort_cpurst", cpu_rst, 1);
      chk("abort_ldrdy", ld_ready, 1);
      chk("abort_cnt", instr_count, 4);
      chk("abort_cause", halt_cause, 0);
      run_chk("nodrop", 1, 0, 0, 6, 1, 1, 1, 1);
      start("midrst", 4, 0, 0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_cpurst", cpu_rst, 1);
      chk("mr_cpuin", cpu_in, 0);
      chk("mr_status", {halt_cause, final_pc, final_acc, instr_count}, 0);
      @(negedge clk);
      rst = 1'b0;
      run_chk("cleared", 1, 0, 0, 6, 1, 1, 0, 1);
      ld(0, 6'b100011); ld(1, 6'b001000); ld(2, 6'b010000);
      run_chk("rerun", 3, 0, 0, 10, 1, 3, 6, 3);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
